// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one combinational adder/subtractor between two requesters.
// Round-robin arbitration on the request side, valid/ready handshakes on both the
// request and response sides. Operands are driven to the unit from registers and
// the result is captured one cycle later, then offered to the granted requester.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqX_valid/ready/m/a/b        request channel X (m: 0 add, 1 subtract)
//   rspX_valid/ready              response channel X
//   rsp_s, rsp_cout               captured result, shared by both response channels
//   au_m, au_a, au_b              registered operands to the shared unit
//   au_s, au_cout                 result from the shared unit
//   busy                          FSM not in IDLE
//   grant_id                      owner of the current or last operation
//   ops_done                      completed response handshakes, wrapping
module addsub_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_m,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_m,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic             au_m,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    input  logic [WIDTH-1:0] au_s,
    input  logic             au_cout,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   prio_q;
    logic   winner_c;
    logic   accept_c;
    logic   rsp_hs_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, arbitration and handshake decode
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept_c   = 1'b0;
        rsp_hs_c   = 1'b0;
        winner_c   = prio_q;

        // A lone requester wins outright; the pointer only breaks ties
        if (req0_valid && !req1_valid) begin
            winner_c = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            winner_c = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_c   = 1'b1;
                    req0_ready = !winner_c && req0_valid;
                    req1_ready = winner_c && req1_valid;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's ready completes the response
                rsp_hs_c = grant_id ? rsp1_ready : rsp0_ready;
                if (rsp_hs_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand, result, ownership and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_m       <= 1'b0;
            au_a       <= '0;
            au_b       <= '0;
            grant_id   <= 1'b0;
            prio_q     <= 1'b0;
            rsp_s      <= '0;
            rsp_cout   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            ops_done   <= '0;
        end else begin
            // Operands persist until the next acceptance
            if (accept_c) begin
                au_m     <= winner_c ? req1_m : req0_m;
                au_a     <= winner_c ? req1_a : req0_a;
                au_b     <= winner_c ? req1_b : req0_b;
                grant_id <= winner_c;
            end
            if (state_q == ST_EXEC) begin
                rsp_s    <= au_s;
                rsp_cout <= au_cout;
            end
            if (rsp_hs_c) begin
                prio_q   <= ~grant_id;
                ops_done <= ops_done + CNT_W'(1);
            end
            // grant_id is stable from EXEC through RESP, so it selects the channel
            rsp0_valid <= (state_d == ST_RESP) && !grant_id;
            rsp1_valid <= (state_d == ST_RESP) && grant_id;
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural adder/subtractor on the au_* side.
module tb_addsub_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_m;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_m;
    logic [W-1:0]  req1_a, req1_b;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0]  rsp_s;
    logic          rsp_cout;
    logic          au_m;
    logic [W-1:0]  au_a, au_b, au_s;
    logic          au_cout;
    logic          busy, grant_id;
    logic [CW-1:0] ops_done;
    logic [W:0]    au_sum;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_s(rsp_s), .rsp_cout(rsp_cout),
        .au_m(au_m), .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cout(au_cout),
        .busy(busy), .grant_id(grant_id), .ops_done(ops_done)
    );

    // Shared adder/subtractor: subtract is A + ~B + 1, cout=1 means no borrow
    always_comb begin
        if (au_m) au_sum = {1'b0, au_a} + {1'b0, ~au_b} + (W+1)'(1);
        else      au_sum = {1'b0, au_a} + {1'b0, au_b};
        au_s    = au_sum[W-1:0];
        au_cout = au_sum[W];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Single uncontended operation on channel id, checking every stage
    task automatic run_op(input logic id, input logic m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] es,
                          input logic ec, input logic [CW-1:0] eops);
        if (id) begin req1_valid = 1'b1; req1_m = m; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_m = m; req0_a = a; req0_b = b; end
        #1;
        chk("op_ready0", 32'(req0_ready), 32'(!id));
        chk("op_ready1", 32'(req1_ready), 32'(id));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("op_au_m", 32'(au_m), 32'(m));
        chk("op_au_a", 32'(au_a), 32'(a));
        chk("op_au_b", 32'(au_b), 32'(b));
        chk("op_grant", 32'(grant_id), 32'(id));
        chk("op_busy", 32'(busy), 32'(1));
        chk("op_exec_novalid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
        tick();
        chk("op_rsp_valid", 32'({rsp1_valid, rsp0_valid}), id ? 32'(2) : 32'(1));
        chk("op_rsp_s", 32'(rsp_s), 32'(es));
        chk("op_rsp_cout", 32'(rsp_cout), 32'(ec));
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("op_ops_done", 32'(ops_done), 32'(eops));
        chk("op_idle", 32'({busy, rsp1_valid, rsp0_valid}), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_m = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_m = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_au", 32'({au_m, au_a, au_b}), 32'(0));
        chk("rst_rsp", 32'({rsp_s, rsp_cout, rsp1_valid, rsp0_valid}), 32'(0));
        chk("rst_status", 32'({busy, grant_id, ops_done}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Add on req0, subtract on req1 (including borrow case)
        run_op(1'b0, 1'b0, 4'b1010, 4'b0011, 4'b1101, 1'b0, 8'd1);
        run_op(1'b1, 1'b1, 4'b1010, 4'b0011, 4'b0111, 1'b1, 8'd2);
        run_op(1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0001, 1'b0, 8'd3);

        // Contention from reset: grants alternate, three cycles per op
        do_reset();
        req0_valid = 1'b1; req0_m = 1'b0; req0_a = 4'b1111; req0_b = 4'b1111;
        req1_valid = 1'b1; req1_m = 1'b1; req1_a = 4'b1100; req1_b = 4'b0010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", 32'({req1_ready, req0_ready}), (i % 2) ? 32'(2) : 32'(1));
            tick();
            tick();
            chk("rr_grant", 32'(grant_id), 32'(i % 2));
            chk("rr_valid", 32'({rsp1_valid, rsp0_valid}), (i % 2) ? 32'(2) : 32'(1));
            chk("rr_s", 32'(rsp_s), (i % 2) ? 32'(4'b1010) : 32'(4'b1110));
            chk("rr_cout", 32'(rsp_cout), 32'(1));
            tick();
        end
        chk("rr_ops", 32'(ops_done), 32'(6));

        // Response backpressure: owner withholds ready, non-owner ready ignored
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_a = 4'b0101; req0_b = 4'b0110;
        #1;
        chk("bp_ready0", 32'(req0_ready), 32'(1));
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rsp1_ready = (i % 2 == 0);
            #1;
            chk("bp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(1));
            chk("bp_s", 32'({rsp_s, rsp_cout}), 32'({4'b1011, 1'b0}));
            chk("bp_busy", 32'(busy), 32'(1));
            chk("bp_req1_ready", 32'(req1_ready), 32'(0));
            tick();
        end
        rsp1_ready = 1'b0;
        chk("bp_ops_hold", 32'(ops_done), 32'(6));
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("bp_ops", 32'(ops_done), 32'(7));
        chk("bp_req1_wins", 32'(req1_ready), 32'(1));
        rsp1_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_r1_s", 32'({rsp1_valid, rsp_s}), 32'({1'b1, 4'b1010}));
        tick();
        rsp1_ready = 1'b0;
        chk("bp_ops2", 32'(ops_done), 32'(8));

        // Reset during EXEC
        req0_valid = 1'b1; req0_m = 1'b0; req0_a = 4'b0011; req0_b = 4'b0100;
        tick();
        req0_valid = 1'b0;
        chk("rx_busy_before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rx_au", 32'({au_m, au_a, au_b}), 32'(0));
        chk("rx_status", 32'({busy, grant_id, ops_done}), 32'(0));
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rx_after", 32'({busy, rsp1_valid, rsp0_valid}), 32'(0));

        // Reset during RESP
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("rr_resp_before", 32'({rsp0_valid, rsp_s}), 32'({1'b1, 4'b0111}));
        rst_n = 1'b0;
        #1;
        chk("rr_resp_rst", 32'({rsp_s, rsp_cout, rsp1_valid, rsp0_valid}), 32'(0));
        chk("rr_resp_status", 32'({busy, ops_done}), 32'(0));
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rr_resp_after", 32'({busy, rsp1_valid, rsp0_valid, ops_done}), 32'(0));

        // 256 back-to-back ops at exactly three cycles each: counter wraps
        req0_valid = 1'b1; req0_m = 1'b0; req0_a = 4'b0001; req0_b = 4'b0001;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 255 * 3; i++) tick();
        chk("wrap_255", 32'(ops_done), 32'(255));
        chk("wrap_idle", 32'(busy), 32'(0));
        tick(); tick(); tick();
        chk("wrap_0", 32'(ops_done), 32'(0));
        chk("wrap_s", 32'(rsp_s), 32'(4'b0010));
        req0_valid = 1'b0;
        rsp0_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Shares one combinational Adder_Subtractor (M=0 add, M=1 subtract, outputs S and cout) between two requesters. Uses round-robin arbitration and a valid/ready handshake on both the request and response sides. Drives the unit's operands from registers, captures its result one cycle later, and returns the result to the granted requester. Sits between the ALU datapath and its two command sources.

Parameters:
WIDTH, 4, operand and result width; must match the shared Adder_Subtractor.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0's operation is accepted this cycle.
req0_m  in  1  requester 0 mode: 0 add, 1 subtract.
req0_a, req0_b  in  WIDTH  requester 0 operands.
req1_valid, req1_ready, req1_m, req1_a, req1_b  same as requester 0, for requester 1.
rsp0_valid  out  1  result is valid for requester 0.
rsp1_valid  out  1  result is valid for requester 1.
rsp0_ready, rsp1_ready  in  1  requester accepts its result.
rsp_s  out  WIDTH  captured S; shared by both response channels.
rsp_cout  out  1  captured cout.
au_m  out  1  mode driven to the shared unit.
au_a, au_b  out  WIDTH  operands driven to the shared unit.
au_s  in  WIDTH  sum/difference returned by the shared unit.
au_cout  in  1  carry-out returned by the shared unit.
busy  out  1  high whenever the FSM is not in IDLE.
grant_id  out  1  owner of the current or last operation.
ops_done  out  CNT_W  count of completed response handshakes; wraps.

Behaviour:
- Reset (async, rst_n=0): every register clears; the FSM enters IDLE; au_m/au_a/au_b=0, rsp_s=0, rsp_cout=0, rsp0/1_valid=0, busy=0, grant_id=0, ops_done=0, priority pointer=0. Assertion at any point drops any in-flight operation with no response. Release takes effect on the next clk edge.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - winner = the sole valid requester; if both are valid, winner = priority pointer.
  - reqX_ready = (state==IDLE) && (winner==X) && reqX_valid. At most one ready is high per cycle.
  - On handshake: register m/a/b into au_m/au_a/au_b, set grant_id=X, go to EXEC.
- EXEC: exactly one cycle. At the clock edge, capture au_s into rsp_s and au_cout into rsp_cout, then go to RESP. The controller does not modify arithmetic: cout passes through unchanged. For subtract, cout=1 means A>=B unsigned, i.e. no borrow.
- RESP:
  - rspX_valid=1 only for X==grant_id; rsp_s and rsp_cout are held stable.
  - On rspX_ready for the owner: go to IDLE, priority pointer = ~grant_id, ops_done += 1 (wraps modulo 2^CNT_W).
  - The non-owner's rsp_ready is ignored.
- Latency: request handshake at edge N leads to rsp valid from after edge N+1. Minimum 3 cycles per operation; no new request is accepted outside IDLE.
- Requester rules: reqX_valid and operands stay stable until ready. A requester may deassert valid only when not handshaking.
- au_* outputs are held from acceptance until the next acceptance. They are not cleared on completion.
- Simultaneous events:
  - Both requesters valid in IDLE: pointer picks the winner; the loser stays pending and wins next.
  - Response handshake and new request in the same cycle cannot occur, because the FSM returns to IDLE first.
- Starvation freedom: under continuous contention, grants alternate 0,1,0,1…

Test Plan:
- Req0 add A=1010 B=0011 (M=0) -> au_* set the cycle after handshake; rsp0_valid with rsp_s=1101, rsp_cout=0; ops_done=1.
- Req1 subtract A=1010 B=0011 -> rsp1_valid, rsp_s=0111, rsp_cout=1. Then subtract 0000-1111 -> rsp_s=0001, rsp_cout=0.
- Both valid from reset: req0 1111+1111, req1 1100-0010 -> req0 granted first (rsp_s=1110, rsp_cout=1), then req1 (rsp_s=1010, rsp_cout=1). Hold both valid for 6 ops -> grant_id sequence 0,1,0,1,0,1.
- Response backpressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_s stay stable, busy=1, req1_ready stays 0 despite req1_valid=1. Pulsing rsp1_ready in that window has no effect.
- Reset asserted during EXEC and again during RESP -> all outputs return to reset values immediately; no rsp_valid after release; ops_done=0.
- Issue 256 operations -> ops_done wraps to 0. Check the exact cycle count per op is 3 with rsp_ready tied high.
